// File: rtl/link_memory_2r_1w.sv
// Two-read/one-write mirrored data memory on latency-insensitive links.
// Define TIA_MEMORY_WRITE_FORWARD_EN for write-first link reads.
`timescale 1ns/1ps

package tia_pkg;
  localparam int TIA_WORD_WIDTH       = 32;
  localparam int TIA_TAG_WIDTH        = 3;
  localparam int TIA_MMIO_INDEX_WIDTH = 32;
  localparam int TIA_MMIO_DATA_WIDTH  = 32;
endpackage

module link_memory_dpram #(
  parameter int DEPTH = 32768,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 32
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] ram [DEPTH];

  always_ff @(posedge clock) begin
    if (we) ram[waddr] <= wdata;
  end

  assign rdata = ram[raddr];
endmodule

module link_memory_2r_1w
  import tia_pkg::*;
#(
  parameter int DEPTH = 32768
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,

  input  logic                            host_read_req,
  input  logic [TIA_MMIO_INDEX_WIDTH-1:0] host_read_index,
  output logic                            host_read_ack,
  output logic [TIA_MMIO_DATA_WIDTH-1:0]  host_read_data,
  input  logic                            host_write_req,
  input  logic [TIA_MMIO_INDEX_WIDTH-1:0] host_write_index,
  input  logic [TIA_MMIO_DATA_WIDTH-1:0]  host_write_data,
  output logic                            host_write_ack,

  input  logic                      read_index_0_input_link_req,
  output logic                      read_index_0_input_link_ack,
  input  logic [TIA_WORD_WIDTH-1:0] read_index_0_input_link_data,
  input  logic [TIA_TAG_WIDTH-1:0]  read_index_0_input_link_tag,

  output logic                      read_data_0_output_link_req,
  input  logic                      read_data_0_output_link_ack,
  output logic [TIA_WORD_WIDTH-1:0] read_data_0_output_link_data,
  output logic [TIA_TAG_WIDTH-1:0]  read_data_0_output_link_tag,

  input  logic                      read_index_1_input_link_req,
  output logic                      read_index_1_input_link_ack,
  input  logic [TIA_WORD_WIDTH-1:0] read_index_1_input_link_data,
  input  logic [TIA_TAG_WIDTH-1:0]  read_index_1_input_link_tag,

  output logic                      read_data_1_output_link_req,
  input  logic                      read_data_1_output_link_ack,
  output logic [TIA_WORD_WIDTH-1:0] read_data_1_output_link_data,
  output logic [TIA_TAG_WIDTH-1:0]  read_data_1_output_link_tag,

  input  logic                      write_index_input_link_req,
  output logic                      write_index_input_link_ack,
  input  logic [TIA_WORD_WIDTH-1:0] write_index_input_link_data,
  input  logic [TIA_TAG_WIDTH-1:0]  write_index_input_link_tag,

  input  logic                      write_data_input_link_req,
  output logic                      write_data_input_link_ack,
  input  logic [TIA_WORD_WIDTH-1:0] write_data_input_link_data,
  input  logic [TIA_TAG_WIDTH-1:0]  write_data_input_link_tag,

  output logic quiescent
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = TIA_WORD_WIDTH;
  localparam int TW = TIA_TAG_WIDTH;
  localparam int DW = TIA_MMIO_DATA_WIDTH;

  logic          host_busy, link_go, lwr_go;
  logic          hrd_fire, hwr_fire;
  logic          hrd_hold_q, hrd_hold_d;
  logic          hrd_ack_q, hrd_ack_d;
  logic [DW-1:0] hrd_data_q, hrd_data_d;
  logic          hwr_hold_q, hwr_hold_d;
  logic          hwr_ack_q, hwr_ack_d;

  logic          ri0_fire, ri1_fire, lwr_fire;
  logic [AW-1:0] ri0_addr, ri1_addr, lwr_addr;
  logic [AW-1:0] b0_raddr, wr_addr;
  logic          wr_en;
  logic [W-1:0]  wr_data, b0_rdata, b1_rdata;
  logic [W-1:0]  rd0_word, rd1_word;

  logic          o0_req_q, o0_req_d;
  logic [W-1:0]  o0_data_q, o0_data_d;
  logic [TW-1:0] o0_tag_q, o0_tag_d;
  logic          o1_req_q, o1_req_d;
  logic [W-1:0]  o1_data_q, o1_data_d;
  logic [TW-1:0] o1_tag_q, o1_tag_d;

  // Host traffic starves every link while a request is pending.
  assign host_busy = host_read_req | host_write_req;
  assign link_go   = enable & ~host_busy & ~reset;

  assign read_index_0_input_link_ack =
    link_go & (~o0_req_q | read_data_0_output_link_ack);
  assign read_index_1_input_link_ack =
    link_go & (~o1_req_q | read_data_1_output_link_ack);

  assign lwr_go = link_go & write_index_input_link_req
                & write_data_input_link_req;
  assign write_index_input_link_ack = lwr_go;
  assign write_data_input_link_ack  = lwr_go;

  assign ri0_fire = read_index_0_input_link_req
                  & read_index_0_input_link_ack;
  assign ri1_fire = read_index_1_input_link_req
                  & read_index_1_input_link_ack;
  assign lwr_fire = lwr_go;

  assign ri0_addr = read_index_0_input_link_data[AW-1:0];
  assign ri1_addr = read_index_1_input_link_data[AW-1:0];
  assign lwr_addr = write_index_input_link_data[AW-1:0];

  assign hrd_fire = ~reset & host_read_req & ~hrd_hold_q;
  assign hwr_fire = ~reset & host_write_req & ~hwr_hold_q;

  assign b0_raddr = hrd_fire ? host_read_index[AW-1:0] : ri0_addr;
  assign wr_en    = hwr_fire | lwr_fire;
  assign wr_addr  = hwr_fire ? host_write_index[AW-1:0] : lwr_addr;
  assign wr_data  = hwr_fire ? host_write_data
                             : write_data_input_link_data;

  link_memory_dpram #(.DEPTH(DEPTH), .AW(AW), .W(W)) dpram0 (
    .clock (clock),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (b0_raddr),
    .rdata (b0_rdata)
  );

  link_memory_dpram #(.DEPTH(DEPTH), .AW(AW), .W(W)) dpram1 (
    .clock (clock),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (ri1_addr),
    .rdata (b1_rdata)
  );

`ifdef TIA_MEMORY_WRITE_FORWARD_EN
  assign rd0_word = (lwr_fire && lwr_addr == ri0_addr)
                  ? write_data_input_link_data : b0_rdata;
  assign rd1_word = (lwr_fire && lwr_addr == ri1_addr)
                  ? write_data_input_link_data : b1_rdata;
`else
  assign rd0_word = b0_rdata;
  assign rd1_word = b1_rdata;
`endif

  always_comb begin
    hrd_hold_d = host_read_req & (hrd_hold_q | hrd_fire);
    hrd_ack_d  = hrd_fire;
    hrd_data_d = hrd_fire ? b0_rdata : hrd_data_q;
    hwr_hold_d = host_write_req & (hwr_hold_q | hwr_fire);
    hwr_ack_d  = hwr_fire;
  end

  always_comb begin
    o0_req_d  = o0_req_q;
    o0_data_d = o0_data_q;
    o0_tag_d  = o0_tag_q;
    if (ri0_fire) begin
      o0_req_d  = 1'b1;
      o0_data_d = rd0_word;
      o0_tag_d  = read_index_0_input_link_tag;
    end else if (enable && read_data_0_output_link_ack) begin
      o0_req_d = 1'b0;
    end
  end

  always_comb begin
    o1_req_d  = o1_req_q;
    o1_data_d = o1_data_q;
    o1_tag_d  = o1_tag_q;
    if (ri1_fire) begin
      o1_req_d  = 1'b1;
      o1_data_d = rd1_word;
      o1_tag_d  = read_index_1_input_link_tag;
    end else if (enable && read_data_1_output_link_ack) begin
      o1_req_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hrd_hold_q <= 1'b0;
      hrd_ack_q  <= 1'b0;
      hrd_data_q <= '0;
      hwr_hold_q <= 1'b0;
      hwr_ack_q  <= 1'b0;
      o0_req_q   <= 1'b0;
      o0_data_q  <= '0;
      o0_tag_q   <= '0;
      o1_req_q   <= 1'b0;
      o1_data_q  <= '0;
      o1_tag_q   <= '0;
    end else begin
      hrd_hold_q <= hrd_hold_d;
      hrd_ack_q  <= hrd_ack_d;
      hrd_data_q <= hrd_data_d;
      hwr_hold_q <= hwr_hold_d;
      hwr_ack_q  <= hwr_ack_d;
      o0_req_q   <= o0_req_d;
      o0_data_q  <= o0_data_d;
      o0_tag_q   <= o0_tag_d;
      o1_req_q   <= o1_req_d;
      o1_data_q  <= o1_data_d;
      o1_tag_q   <= o1_tag_d;
    end
  end

  assign host_read_ack  = hrd_ack_q;
  assign host_read_data = hrd_data_q;
  assign host_write_ack = hwr_ack_q;

  assign read_data_0_output_link_req  = o0_req_q;
  assign read_data_0_output_link_data = o0_data_q;
  assign read_data_0_output_link_tag  = o0_tag_q;
  assign read_data_1_output_link_req  = o1_req_q;
  assign read_data_1_output_link_data = o1_data_q;
  assign read_data_1_output_link_tag  = o1_tag_q;

  assign quiescent = ~(read_index_0_input_link_req
                     | read_index_1_input_link_req
                     | write_index_input_link_req
                     | write_data_input_link_req
                     | o0_req_q | o1_req_q);

  // Index bits above the bank size wrap; tags on the write side carry nothing.
  logic unused_bits;
  assign unused_bits = ^{read_index_0_input_link_data[W-1:AW],
                         read_index_1_input_link_data[W-1:AW],
                         write_index_input_link_data[W-1:AW],
                         write_index_input_link_tag,
                         write_data_input_link_tag,
                         host_read_index[TIA_MMIO_INDEX_WIDTH-1:AW],
                         host_write_index[TIA_MMIO_INDEX_WIDTH-1:AW]};
endmodule

// File: tb/tb_link_memory_2r_1w.sv
// Bench for link_memory_2r_1w: directed steps plus random link traffic
// checked against an array/queue model of the memory.
`timescale 1ns/1ps

module tb_link_memory_2r_1w;
  localparam int DEPTH = 32768;

  logic clock = 1'b0;
  logic reset, enable;
  logic host_read_req, host_read_ack, host_write_req, host_write_ack;
  logic [31:0] host_read_index, host_read_data;
  logic [31:0] host_write_index, host_write_data;
  logic ri0_req, ri0_ack, ri1_req, ri1_ack;
  logic [31:0] ri0_data, ri1_data;
  logic [2:0] ri0_tag, ri1_tag;
  logic o0_req, o0_ack, o1_req, o1_ack;
  logic [31:0] o0_data, o1_data;
  logic [2:0] o0_tag, o1_tag;
  logic wi_req, wi_ack, wd_req, wd_ack;
  logic [31:0] wi_data, wd_data;
  logic [2:0] wi_tag, wd_tag;
  logic quiescent;

  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] mem [int];
  logic [31:0] q0d[$], q1d[$];
  logic [2:0]  q0t[$], q1t[$];

  always #5 clock = ~clock;

  link_memory_2r_1w #(.DEPTH(DEPTH)) dut (
    .clock (clock), .reset (reset), .enable (enable),
    .host_read_req (host_read_req), .host_read_index (host_read_index),
    .host_read_ack (host_read_ack), .host_read_data (host_read_data),
    .host_write_req (host_write_req), .host_write_index (host_write_index),
    .host_write_data (host_write_data), .host_write_ack (host_write_ack),
    .read_index_0_input_link_req (ri0_req),
    .read_index_0_input_link_ack (ri0_ack),
    .read_index_0_input_link_data (ri0_data),
    .read_index_0_input_link_tag (ri0_tag),
    .read_data_0_output_link_req (o0_req),
    .read_data_0_output_link_ack (o0_ack),
    .read_data_0_output_link_data (o0_data),
    .read_data_0_output_link_tag (o0_tag),
    .read_index_1_input_link_req (ri1_req),
    .read_index_1_input_link_ack (ri1_ack),
    .read_index_1_input_link_data (ri1_data),
    .read_index_1_input_link_tag (ri1_tag),
    .read_data_1_output_link_req (o1_req),
    .read_data_1_output_link_ack (o1_ack),
    .read_data_1_output_link_data (o1_data),
    .read_data_1_output_link_tag (o1_tag),
    .write_index_input_link_req (wi_req),
    .write_index_input_link_ack (wi_ack),
    .write_index_input_link_data (wi_data),
    .write_index_input_link_tag (wi_tag),
    .write_data_input_link_req (wd_req),
    .write_data_input_link_ack (wd_ack),
    .write_data_input_link_data (wd_data),
    .write_data_input_link_tag (wd_tag),
    .quiescent (quiescent)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic links_idle();
    ri0_req = 0; ri1_req = 0; wi_req = 0; wd_req = 0;
  endtask

  task automatic host_write(input int idx, input logic [31:0] d);
    host_write_req = 1; host_write_index = idx; host_write_data = d;
    ri0_req = 1; wi_req = 1; wd_req = 1;
    #1;
    check("hw_ri0_ack_low", ri0_ack, 0);
    check("hw_wi_ack_low", wi_ack, 0);
    step();
    check("hw_ack_pulse", host_write_ack, 1);
    host_write_req = 0;
    links_idle();
    step();
    check("hw_ack_end", host_write_ack, 0);
    mem[idx % DEPTH] = d;
  endtask

  task automatic host_read(input int idx, input logic [31:0] exp);
    host_read_req = 1; host_read_index = idx;
    #1;
    check("hr_ri1_ack_low", ri1_ack, 0);
    step();
    check("hr_ack_pulse", host_read_ack, 1);
    check("hr_data", host_read_data, exp);
    step();
    check("hr_no_reack", host_read_ack, 0);
    host_read_req = 0;
    step();
  endtask

  function automatic logic [31:0] fwd_val(input int a, input logic wr,
                                          input int wa, input logic [31:0] wv);
`ifdef TIA_MEMORY_WRITE_FORWARD_EN
    if (wr && wa == a) return wv;
`endif
    return mem[a];
  endfunction

  initial begin
    logic en, expw, exp0, exp1;
    int a0, a1, wa;
    logic [31:0] wv, same_exp;

    reset = 1; enable = 1;
    host_read_req = 0; host_read_index = 0;
    host_write_req = 0; host_write_index = 0; host_write_data = 0;
    links_idle();
    ri0_data = 0; ri1_data = 0; wi_data = 0; wd_data = 0;
    ri0_tag = 0; ri1_tag = 0; wi_tag = 0; wd_tag = 0;
    o0_ack = 1; o1_ack = 1;
    step(); step();
    check("rst_o0_req", o0_req, 0);
    check("rst_o1_req", o1_req, 0);
    check("rst_ri0_ack", ri0_ack, 0);
    check("rst_ri1_ack", ri1_ack, 0);
    check("rst_wi_ack", wi_ack, 0);
    check("rst_read_ack", host_read_ack, 0);
    check("rst_write_ack", host_write_ack, 0);
    check("rst_read_data", host_read_data, 0);
    check("rst_quiescent", quiescent, 1);
    reset = 0;
    step();

    // Dual read of a preloaded word
    host_write(5, 32'hDEADBEEF);
    ri0_req = 1; ri0_data = 5; ri0_tag = 2;
    ri1_req = 1; ri1_data = 5; ri1_tag = 5;
    #1;
    check("dual_ri0_ack", ri0_ack, 1);
    check("dual_ri1_ack", ri1_ack, 1);
    step();
    links_idle();
    check("dual_o0_req", o0_req, 1);
    check("dual_o0_data", o0_data, 32'hDEADBEEF);
    check("dual_o0_tag", o0_tag, 2);
    check("dual_o1_data", o1_data, 32'hDEADBEEF);
    check("dual_o1_tag", o1_tag, 5);
    step();
    check("dual_drained", o0_req, 0);

    // Link write then read on both ports
    wi_req = 1; wi_data = 10; wd_req = 1; wd_data = 32'h1234;
    #1;
    check("lw_wi_ack", wi_ack, 1);
    check("lw_wd_ack", wd_ack, 1);
    step();
    links_idle();
    mem[10] = 32'h1234;
    ri0_req = 1; ri0_data = 10; ri1_req = 1; ri1_data = 10;
    step();
    links_idle();
    check("lw_o0_data", o0_data, 32'h1234);
    check("lw_o1_data", o1_data, 32'h1234);
    step();

    // Backpressure on port 0
    o0_ack = 0;
    ri0_req = 1; ri0_data = 5;
    step();
    ri0_data = 10;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_ri0_ack_low", ri0_ack, 0);
      check("bp_o0_req", o0_req, 1);
      check("bp_o0_stable", o0_data, 32'hDEADBEEF);
      step();
    end
    o0_ack = 1;
    #1;
    check("bp_ri0_ack_rel", ri0_ack, 1);
    step();
    ri0_req = 0;
    check("bp_second", o0_data, 32'h1234);
    check("bp_second_req", o0_req, 1);
    step();
    check("bp_drained", o0_req, 0);

    // Host write then read
    host_write(7, 32'hAA);
    host_read(7, 32'hAA);

    // Index wrap and same-cycle read/write
    host_write(3, 32'h55);
    ri0_req = 1; ri0_data = DEPTH + 3; ri0_tag = 1;
    step();
    links_idle();
    check("wrap_data", o0_data, 32'h55);
    check("wrap_tag", o0_tag, 1);
    step();
    same_exp = fwd_val(3, 1, 3, 32'h66);
    ri0_req = 1; ri0_data = 3; ri1_req = 1; ri1_data = 3;
    wi_req = 1; wi_data = 3; wd_req = 1; wd_data = 32'h66;
    step();
    links_idle();
    mem[3] = 32'h66;
    check("raw_o0", o0_data, same_exp);
    check("raw_o1", o1_data, same_exp);
    step();
    host_read(3, 32'h66);

    // enable low holds the output register
    o0_ack = 0;
    ri0_req = 1; ri0_data = 7;
    step();
    ri0_req = 0;
    check("en_o0_req", o0_req, 1);
    enable = 0; o0_ack = 1; ri0_req = 1; ri0_data = 5;
    #1;
    check("en_ri0_ack_low", ri0_ack, 0);
    step();
    check("en_hold_req", o0_req, 1);
    check("en_hold_data", o0_data, 32'hAA);
    check("en_not_quiet", quiescent, 0);
    ri0_req = 0; enable = 1;
    step();
    check("en_drained", o0_req, 0);

    // Reset with pending output
    o0_ack = 0;
    ri0_req = 1; ri0_data = 3;
    step();
    ri0_req = 0;
    check("rp_pending", o0_req, 1);
    reset = 1;
    step();
    check("rp_o0_req", o0_req, 0);
    check("rp_quiescent", quiescent, 1);
    reset = 0; o0_ack = 1;
    step();
    host_read(3, 32'h66);

    // Random link traffic against the model
    for (int i = 0; i < 16; i++) host_write(i, $urandom);
    for (int c = 0; c < 400; c++) begin
      en = ($urandom % 8) != 0;
      enable = en;
      a0 = $urandom % 16; a1 = $urandom % 16; wa = $urandom % 16;
      wv = $urandom;
      ri0_req = $urandom % 2; ri1_req = $urandom % 2;
      ri0_data = a0 + ((($urandom % 4) == 0) ? DEPTH : 0);
      ri1_data = a1 + ((($urandom % 4) == 0) ? DEPTH : 0);
      ri0_tag = $urandom; ri1_tag = $urandom;
      wi_req = ($urandom % 3) != 0; wd_req = ($urandom % 3) != 0;
      wi_data = wa + ((($urandom % 4) == 0) ? DEPTH : 0);
      wd_data = wv;
      o0_ack = $urandom % 2; o1_ack = $urandom % 2;
      #1;
      exp0 = en && (q0d.size() == 0 || o0_ack);
      exp1 = en && (q1d.size() == 0 || o1_ack);
      expw = en && wi_req && wd_req;
      check("rnd_ri0_ack", ri0_ack, exp0);
      check("rnd_ri1_ack", ri1_ack, exp1);
      check("rnd_wi_ack", wi_ack, expw);
      check("rnd_wd_ack", wd_ack, expw);
      check("rnd_o0_req", o0_req, q0d.size() != 0);
      check("rnd_o1_req", o1_req, q1d.size() != 0);
      if (q0d.size() != 0) begin
        check("rnd_o0_data", o0_data, q0d[0]);
        check("rnd_o0_tag", o0_tag, q0t[0]);
      end
      if (q1d.size() != 0) begin
        check("rnd_o1_data", o1_data, q1d[0]);
        check("rnd_o1_tag", o1_tag, q1t[0]);
      end
      check("rnd_quiescent", quiescent,
            !(ri0_req || ri1_req || wi_req || wd_req ||
              q0d.size() != 0 || q1d.size() != 0));
      if (q0d.size() != 0 && en && o0_ack) begin
        void'(q0d.pop_front()); void'(q0t.pop_front());
      end
      if (q1d.size() != 0 && en && o1_ack) begin
        void'(q1d.pop_front()); void'(q1t.pop_front());
      end
      if (ri0_req && exp0) begin
        q0d.push_back(fwd_val(a0, expw, wa, wv)); q0t.push_back(ri0_tag);
      end
      if (ri1_req && exp1) begin
        q1d.push_back(fwd_val(a1, expw, wa, wv)); q1t.push_back(ri1_tag);
      end
      if (expw) mem[wa] = wv;
      step();
    end
    links_idle();
    enable = 1; o0_ack = 1; o1_ack = 1;
    step(); step();
    check("end_quiescent", quiescent, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
